branch_unit: RTL

BRANCH_UNIT -- requirements
Module: branch_unit

---
 rtl/branch_unit_pkg.sv | 22 ++
 rtl/branch_unit_cond.sv | 36 +++
 rtl/branch_unit.sv | 130 +++++++++++++
 3 files changed

// File: rtl/branch_unit_pkg.sv
// Shared FSM encodings and branch condition codes for branch_unit and its bench.
package branch_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EVAL   = 2'd1,
    ST_UPDATE = 2'd2
  } state_t;

  localparam logic [2:0] COND_B  = 3'b000;
  localparam logic [2:0] COND_EQ = 3'b001;
  localparam logic [2:0] COND_NE = 3'b010;
  localparam logic [2:0] COND_LT = 3'b011;
  localparam logic [2:0] COND_LE = 3'b100;
  localparam logic [2:0] COND_BL = 3'b111;

  // Bit positions inside the {Z,V,N} status word.
  localparam int ST_Z = 2;
  localparam int ST_V = 1;
  localparam int ST_N = 0;

endpackage

// File: rtl/branch_unit_cond.sv
// Combinational branch-condition decode against {Z,V,N}; cond 111 is
// branch-and-link only when BRANCH_LINK_EN is defined, otherwise unsupported.
module cond_eval
  import branch_unit_pkg::*;
(
  input  logic [2:0] cond,
  input  logic [2:0] status,
  output logic       take,
  output logic       bad
);

  logic w_z;
  logic w_v;
  logic w_n;

  assign w_z = status[ST_Z];
  assign w_v = status[ST_V];
  assign w_n = status[ST_N];

  always_comb begin
    take = 1'b0;
    bad  = 1'b0;
    case (cond)
      COND_B:  take = 1'b1;
      COND_EQ: take = w_z;
      COND_NE: take = ~w_z;
      COND_LT: take = w_n ^ w_v;
      COND_LE: take = (w_n ^ w_v) | w_z;
`ifdef BRANCH_LINK_EN
      COND_BL: take = 1'b1;
`endif
      default: bad = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_unit.sv
// Three-state branch unit (IDLE/EVAL/UPDATE) owning pc and the {Z,V,N} status.
// Optional link register output lr when BRANCH_LINK_EN is defined.
module branch_unit
  import branch_unit_pkg::*;
#(
  parameter int PC_W  = 9,
  parameter int OFF_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_s,
  input  logic [2:0]       z_in,
  input  logic             start,
  input  logic [2:0]       cond,
  input  logic [OFF_W-1:0] imm,
  input  logic             pc_inc,
  output logic [PC_W-1:0]  pc,
  output logic [2:0]       status,
  output logic             taken,
  output logic             illegal,
`ifdef BRANCH_LINK_EN
  output logic [PC_W-1:0]  lr,
`endif
  output logic             done
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [2:0]       r_cond;
  logic [OFF_W-1:0] r_imm;
  logic [PC_W-1:0]  r_pc;
  logic [2:0]       r_status;
  logic             r_taken;
  logic             r_illegal;
  logic             r_done;

  logic             w_accept;
  logic             w_eval;
  logic             w_update;
  logic             w_inc;
  logic             w_take;
  logic             w_bad;
  logic [PC_W-1:0]  w_pc_seq;
  logic [PC_W-1:0]  w_off;

  cond_eval u_cond_eval (
    .cond   (r_cond),
    .status (r_status),
    .take   (w_take),
    .bad    (w_bad)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (start) w_state_nxt = ST_EVAL;
      ST_EVAL:   w_state_nxt = ST_UPDATE;
      ST_UPDATE: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // start wins over pc_inc; both are ignored outside IDLE.
  always_comb begin
    w_accept = 1'b0;
    w_eval   = 1'b0;
    w_update = 1'b0;
    w_inc    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_accept = start;
        w_inc    = pc_inc & ~start;
      end
      ST_EVAL:   w_eval   = 1'b1;
      ST_UPDATE: w_update = 1'b1;
      default:   ;
    endcase
  end

  assign w_pc_seq = r_pc + PC_W'(1);
  assign w_off    = PC_W'($signed(r_imm));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cond    <= '0;
      r_imm     <= '0;
      r_pc      <= '0;
      r_status  <= '0;
      r_taken   <= 1'b0;
      r_illegal <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      if (load_s) r_status <= z_in;
      if (w_accept) begin
        r_cond <= cond;
        r_imm  <= imm;
      end
      if (w_eval) begin
        r_taken   <= w_take;
        r_illegal <= w_bad;
      end
      if (w_update)   r_pc <= r_taken ? (w_pc_seq + w_off) : w_pc_seq;
      else if (w_inc) r_pc <= w_pc_seq;
      r_done <= w_update;
    end
  end

`ifdef BRANCH_LINK_EN
  logic [PC_W-1:0] r_lr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                              r_lr <= '0;
    else if (w_update && r_cond == COND_BL) r_lr <= w_pc_seq;
  end

  assign lr = r_lr;
`endif

  assign pc      = r_pc;
  assign status  = r_status;
  assign taken   = r_taken;
  assign illegal = r_illegal;
  assign done    = r_done;

endmodule
